pc_fetch_ctrl: RTL and testbench
================================

// Module: pc_fetch_ctrl
// PURPOSE
// Program-counter register and fetch controller feeding the PC adder and instruction memory.
// Holds the PC and issues fetch requests. Stalls on hazard or an imem miss.
// Resolves B/BR branches from decode and redirects fetch, with a one-entry pending-redirect buffer.
// Stops at HLT. Output pc drives imem address; pc_plus2 comes from the adder_pc instance (Sub=0, B=2).
// PARAMETERS
// RESET_PC  16'h0000  PC value loaded on reset
// PORTS
// clk            in   1   system clock
// rst            in   1   synchronous, active-high reset
// stall          in   1   hazard-unit stall; hold PC
// imem_ready     in   1   imem returned instruction this cycle
// halt_fetch     in   1   instruction currently fetched is HLT
// branch_valid   in   1   1-cycle pulse: decode holds a branch
// branch_reg     in   1   0 = B (PC-relative), 1 = BR (register)
// ccc            in   3   branch condition code
// flag_n/z/v     in   1   each  current N, Z, V flags
// imm9           in   9   B offset, in halfwords, signed
// br_pc_plus2    in   16  PC+2 of the branch instruction
// rs_data        in   16  BR target register value
// pc             out  16  current fetch address
// pc_plus2       out  16  pc + 2 (combinational via adder_pc)
// imem_req       out  1   fetch request
// flush          out  1   1-cycle pulse: squash IF/ID, redirect applied
// halted         out  1   core halted (sticky until rst)
// BEHAVIOUR
// - Reset (sync, rst=1 at posedge): pc=RESET_PC, state=FETCH, pend_vld=0, flush=0, halted=0.
// - States: FETCH, WAIT, HALT. imem_req = (state != HALT).
// - advance = (state==FETCH || state==WAIT) & imem_ready & ~stall.
// - FETCH: if ~imem_ready -> WAIT (pc held).
// - WAIT: held until imem_ready; then same rules as FETCH.
// - HALT: terminal until rst. All inputs are ignored; pc is frozen.
// - taken = branch_valid & cond(ccc,N,Z,V). Condition codes:
//   - 000 NE: ~Z
//   - 001 EQ: Z
//   - 010 GT: ~Z&~N
//   - 011 LT: N
//   - 100 GE: Z|(~Z&~N)
//   - 101 LE: N|Z
//   - 110 OVF: V
//   - 111 always
// - Branch target:
//   - B: br_pc_plus2 + (sext(imm9)<<1), mod 2^16; wrap-around is silent.
//   - BR: rs_data.
// - Taken branch while advance=1: pc <= target at next edge; flush=1 for that cycle (registered, 1 cycle).
// - Taken branch while advance=0: target latched into pend_pc, pend_vld=1.
//   - At next advance: pc <= pend_pc, flush=1, pend_vld cleared.
// - New taken branch while pend_vld=1: overwrites pend_pc (youngest wins).
// - Not-taken branch: no effect.
// - Priority on an advance edge: taken/pending redirect > halt_fetch > pc <= pc_plus2.
// - halt_fetch on advance with no redirect: -> HALT, halted=1 next cycle, pc unchanged (points at HLT).
// - halt_fetch coincident with a redirect is ignored (wrong-path HLT).
// - pc 16'hFFFE + 2 wraps to 16'h0000.
// - rst mid-WAIT or with pend_vld=1: all state is cleared; the pending redirect is lost.
// - Latency: redirect is visible on pc one cycle after the branch_valid pulse when advancing.
// STRUCTURE
// - Shared package wisc_pkg:
//   - CCC_* localparams (8 encodings).
//   - fetch_state_t enum {FETCH, WAIT, HALT}.
//   - RESET_PC default.
// - Sub-module branch_cond: combinational (ccc, N, Z, V) -> taken.
// - Two adder_pc instances: pc+2 and the B-target add. No other arithmetic.
// - Registers: pc, state, pend_vld, pend_pc, flush, halted.
// TESTING
// 1. rst, then imem_ready=1 for 4 cycles -> pc: 0000,0002,0004,0006,0008; flush=0.
// 2. imem_ready=0 for 3 cycles at pc=0004 -> state WAIT, pc held 0004, imem_req=1; ready -> 0006.
// 3. B at br_pc_plus2=0010, imm9=9'h1FC (-4), ccc=111 -> pc=0008 next cycle, flush=1 one cycle.
// 4. BR ccc=001, Z=1, rs_data=1234, with stall=1 -> pend_vld=1, pc held; stall drops -> pc=1234, flush=1.
// 5. ccc=010 with N=1 -> not taken, pc+2 continues. ccc=110 with V=1 -> taken.
// 6. halt_fetch at pc=0020 -> halted=1, imem_req=0, pc stays 0020 for 10 cycles; rst -> pc=0000, halted=0.

Source files
------------

// File: rtl/wisc_pkg.sv
// Shared definitions for the fetch front end: branch condition encodings,
// fetch FSM states and the default reset program counter.
package wisc_pkg;

    localparam logic [15:0] RESET_PC_DEFAULT = 16'h0000;

    localparam logic [2:0] CCC_NE  = 3'b000;
    localparam logic [2:0] CCC_EQ  = 3'b001;
    localparam logic [2:0] CCC_GT  = 3'b010;
    localparam logic [2:0] CCC_LT  = 3'b011;
    localparam logic [2:0] CCC_GE  = 3'b100;
    localparam logic [2:0] CCC_LE  = 3'b101;
    localparam logic [2:0] CCC_OVF = 3'b110;
    localparam logic [2:0] CCC_ALW = 3'b111;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HALT  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/adder_pc.sv
// 16-bit adder/subtractor used for PC increment and PC-relative branch
// targets. Results wrap modulo 2^16 with no carry or overflow reporting.
module adder_pc (
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    input  logic        i_sub,
    output logic [15:0] o_sum
);

    logic [15:0] w_b_eff;

    // Subtraction is done as a + ~b + 1 so a single adder serves both modes
    assign w_b_eff = i_sub ? ~i_b : i_b;
    assign o_sum   = i_a + w_b_eff + {15'd0, i_sub};

endmodule

// File: rtl/branch_cond.sv
// Evaluates a branch condition code against the current N, Z, V flags.
module branch_cond
    import wisc_pkg::*;
(
    input  logic [2:0] i_ccc,
    input  logic       i_n,
    input  logic       i_z,
    input  logic       i_v,
    output logic       o_taken
);

    // Decode the condition code into a single taken/not-taken decision
    always_comb begin
        o_taken = 1'b0;
        case (i_ccc)
            CCC_NE:  o_taken = ~i_z;
            CCC_EQ:  o_taken = i_z;
            CCC_GT:  o_taken = ~i_z & ~i_n;
            CCC_LT:  o_taken = i_n;
            CCC_GE:  o_taken = i_z | (~i_z & ~i_n);
            CCC_LE:  o_taken = i_n | i_z;
            CCC_OVF: o_taken = i_v;
            CCC_ALW: o_taken = 1'b1;
            default: o_taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Program counter and fetch controller. Holds the PC, requests instructions
// from imem, waits on misses and hazard stalls, applies branch redirects
// (buffering one redirect that arrives while fetch cannot advance) and stops
// permanently at HLT until reset.
module pc_fetch_ctrl
    import wisc_pkg::*;
#(
    parameter logic [15:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        imem_ready,
    input  logic        halt_fetch,
    input  logic        branch_valid,
    input  logic        branch_reg,
    input  logic [2:0]  ccc,
    input  logic        flag_n,
    input  logic        flag_z,
    input  logic        flag_v,
    input  logic [8:0]  imm9,
    input  logic [15:0] br_pc_plus2,
    input  logic [15:0] rs_data,
    output logic [15:0] pc,
    output logic [15:0] pc_plus2,
    output logic        imem_req,
    output logic        flush,
    output logic        halted
);

    fetch_state_t r_state;
    logic [15:0]  r_pc;
    logic [15:0]  r_pend_pc;
    logic         r_pend_vld;
    logic         r_flush;
    logic         r_halted;

    logic         w_cond_true;
    logic         w_taken;
    logic         w_advance;
    logic [15:0]  w_b_offset;
    logic [15:0]  w_b_target;
    logic [15:0]  w_target;

    branch_cond u_branch_cond (
        .i_ccc   (ccc),
        .i_n     (flag_n),
        .i_z     (flag_z),
        .i_v     (flag_v),
        .o_taken (w_cond_true)
    );

    adder_pc u_adder_pc_inc (
        .i_a   (r_pc),
        .i_b   (16'h0002),
        .i_sub (1'b0),
        .o_sum (pc_plus2)
    );

    // imm9 is a halfword offset: sign-extend and shift left by one (pure wiring)
    assign w_b_offset = {{6{imm9[8]}}, imm9, 1'b0};

    adder_pc u_adder_pc_btgt (
        .i_a   (br_pc_plus2),
        .i_b   (w_b_offset),
        .i_sub (1'b0),
        .o_sum (w_b_target)
    );

    // Branch resolution and fetch-advance qualification; HALT ignores all inputs
    always_comb begin
        w_target  = branch_reg ? rs_data : w_b_target;
        w_taken   = branch_valid & w_cond_true & (r_state != HALT);
        w_advance = ((r_state == FETCH) || (r_state == WAIT)) & imem_ready & ~stall;
    end

    // PC, fetch state, pending redirect and status registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc       <= RESET_PC;
            r_state    <= FETCH;
            r_pend_vld <= 1'b0;
            r_pend_pc  <= 16'h0000;
            r_flush    <= 1'b0;
            r_halted   <= 1'b0;
        end else begin
            r_flush <= 1'b0;
            case (r_state)
                HALT: begin
                end
                default: begin
                    if (w_advance) begin
                        r_state <= FETCH;
                        if (w_taken) begin
                            r_pc       <= w_target;
                            r_flush    <= 1'b1;
                            r_pend_vld <= 1'b0;
                        end else if (r_pend_vld) begin
                            r_pc       <= r_pend_pc;
                            r_flush    <= 1'b1;
                            r_pend_vld <= 1'b0;
                        end else if (halt_fetch) begin
                            r_state  <= HALT;
                            r_halted <= 1'b1;
                        end else begin
                            r_pc <= pc_plus2;
                        end
                    end else begin
                        r_state <= imem_ready ? FETCH : WAIT;
                        if (w_taken) begin
                            r_pend_pc  <= w_target;
                            r_pend_vld <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign pc       = r_pc;
    assign flush    = r_flush;
    assign halted   = r_halted;
    assign imem_req = (r_state != HALT);

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: directed scenarios followed by randomized traffic.
// Each issued cycle pushes the reference model's expected outputs into a
// queue; an independent monitor pops and compares after every clock edge.
module tb_pc_fetch_ctrl;

    localparam logic [15:0] RESET_VAL = 16'h0000;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        imem_ready;
    logic        halt_fetch;
    logic        branch_valid;
    logic        branch_reg;
    logic [2:0]  ccc;
    logic        flag_n;
    logic        flag_z;
    logic        flag_v;
    logic [8:0]  imm9;
    logic [15:0] br_pc_plus2;
    logic [15:0] rs_data;
    logic [15:0] pc;
    logic [15:0] pc_plus2;
    logic        imem_req;
    logic        flush;
    logic        halted;

    typedef struct {
        logic [15:0] pc;
        logic        flush;
        logic        halted;
        logic        imemReq;
    } expT;

    expT expQ[$];

    int checksTotal  = 0;
    int checksPassed = 0;

    // Reference model state: architectural view only
    logic [15:0] mPc;
    logic [15:0] mPendPc;
    bit          mPendVld;
    bit          mHalted;

    pc_fetch_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .imem_ready   (imem_ready),
        .halt_fetch   (halt_fetch),
        .branch_valid (branch_valid),
        .branch_reg   (branch_reg),
        .ccc          (ccc),
        .flag_n       (flag_n),
        .flag_z       (flag_z),
        .flag_v       (flag_v),
        .imm9         (imm9),
        .br_pc_plus2  (br_pc_plus2),
        .rs_data      (rs_data),
        .pc           (pc),
        .pc_plus2     (pc_plus2),
        .imem_req     (imem_req),
        .flush        (flush),
        .halted       (halted)
    );

    // Free-running clock, period 10
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Branch condition table as written in the ISA description
    function automatic bit condTrue(input logic [2:0] c, input bit n, input bit z, input bit v);
        case (c)
            3'd0: return !z;
            3'd1: return z;
            3'd2: return !z && !n;
            3'd3: return n;
            3'd4: return z || (!z && !n);
            3'd5: return n || z;
            3'd6: return v;
            default: return 1'b1;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        checksTotal++;
        if (act === exp) begin
            checksPassed++;
        end else begin
            $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Drive one cycle of inputs, advance the model, queue the expected result
    task automatic applyStimulus(input bit iRst, input bit iStall, input bit iReady, input bit iHalt,
                                 input bit iBv, input bit iBreg, input logic [2:0] iCcc,
                                 input bit iN, input bit iZ, input bit iV, input logic [8:0] iImm,
                                 input logic [15:0] iBrPc, input logic [15:0] iRs);
        expT e;
        bit adv;
        bit tk;
        bit fl;
        int offs;
        logic [15:0] tgt;
        @(posedge clk);
        #2;
        rst = iRst; stall = iStall; imem_ready = iReady; halt_fetch = iHalt;
        branch_valid = iBv; branch_reg = iBreg; ccc = iCcc;
        flag_n = iN; flag_z = iZ; flag_v = iV;
        imm9 = iImm; br_pc_plus2 = iBrPc; rs_data = iRs;

        fl = 1'b0;
        if (iRst) begin
            mPc = RESET_VAL;
            mPendVld = 1'b0;
            mHalted = 1'b0;
        end else if (!mHalted) begin
            offs = int'($signed(iImm)) * 2;
            tgt = iBreg ? iRs : 16'(int'(iBrPc) + offs);
            tk = iBv && condTrue(iCcc, iN, iZ, iV);
            adv = iReady && !iStall;
            if (adv) begin
                if (tk) begin
                    mPc = tgt; fl = 1'b1; mPendVld = 1'b0;
                end else if (mPendVld) begin
                    mPc = mPendPc; fl = 1'b1; mPendVld = 1'b0;
                end else if (iHalt) begin
                    mHalted = 1'b1;
                end else begin
                    mPc = 16'(int'(mPc) + 2);
                end
            end else if (tk) begin
                mPendPc = tgt;
                mPendVld = 1'b1;
            end
        end
        e.pc = mPc;
        e.flush = fl;
        e.halted = mHalted;
        e.imemReq = !mHalted;
        expQ.push_back(e);
    endtask

    task automatic idle(input bit iReady, input bit iStall);
        applyStimulus(1'b0, iStall, iReady, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 9'd0, 16'h0, 16'h0);
    endtask

    task automatic doReset();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 9'd0, 16'h0, 16'h0);
    endtask

    // Monitor: compare DUT outputs one step after each clock edge
    initial begin
        expT e;
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("pc", pc, e.pc);
                checkOutput("pc_plus2", pc_plus2, 16'(int'(e.pc) + 2));
                checkOutput("flush", {15'd0, flush}, {15'd0, e.flush});
                checkOutput("halted", {15'd0, halted}, {15'd0, e.halted});
                checkOutput("imem_req", {15'd0, imem_req}, {15'd0, e.imemReq});
            end
        end
    end

    // Stimulus: directed scenarios then randomized traffic
    initial begin
        rst = 1'b1; stall = 1'b0; imem_ready = 1'b0; halt_fetch = 1'b0;
        branch_valid = 1'b0; branch_reg = 1'b0; ccc = 3'd0;
        flag_n = 1'b0; flag_z = 1'b0; flag_v = 1'b0;
        imm9 = 9'd0; br_pc_plus2 = 16'h0; rs_data = 16'h0;
        mPc = RESET_VAL; mPendPc = 16'h0; mPendVld = 1'b0; mHalted = 1'b0;

        $display("[TB] sequential fetch");
        doReset();
        doReset();
        for (int i = 0; i < 4; i++) idle(1'b1, 1'b0);

        $display("[TB] imem miss wait");
        doReset();
        idle(1'b1, 1'b0);
        idle(1'b1, 1'b0);
        for (int i = 0; i < 3; i++) idle(1'b0, 1'b0);
        idle(1'b1, 1'b0);

        $display("[TB] B redirect with negative offset");
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd7, 1'b0, 1'b0, 1'b0, 9'h1FC, 16'h0010, 16'h0);
        idle(1'b1, 1'b0);

        $display("[TB] BR under stall goes pending");
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3'd1, 1'b0, 1'b1, 1'b0, 9'h0, 16'h0, 16'h1234);
        idle(1'b1, 1'b1);
        idle(1'b1, 1'b0);
        idle(1'b1, 1'b0);

        $display("[TB] not-taken GT and taken OVF");
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd2, 1'b1, 1'b0, 1'b0, 9'h0, 16'h0, 16'h4444);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd6, 1'b0, 1'b0, 1'b1, 9'h0, 16'h0, 16'h0020);

        $display("[TB] wrong-path HLT alongside redirect is ignored");
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 3'd7, 1'b0, 1'b0, 1'b0, 9'h0, 16'h0, 16'h0020);

        $display("[TB] halt and freeze");
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 9'h0, 16'h0, 16'h0);
        for (int i = 0; i < 10; i++)
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd7, 1'b0, 1'b0, 1'b0, 9'h0, 16'h0, 16'h5555);
        doReset();

        $display("[TB] wrap-around cases");
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd7, 1'b0, 1'b0, 1'b0, 9'h0, 16'h0, 16'hFFFE);
        idle(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd7, 1'b0, 1'b0, 1'b0, 9'h1F0, 16'h0002, 16'h0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd7, 1'b0, 1'b0, 1'b0, 9'h0FF, 16'hFF00, 16'h0);

        $display("[TB] pending overwrite and reset dropping it");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd7, 1'b0, 1'b0, 1'b0, 9'h0, 16'h0, 16'h0100);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3'd7, 1'b0, 1'b0, 1'b0, 9'h0, 16'h0, 16'h0200);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 9'h0, 16'h0, 16'h0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3'd7, 1'b0, 1'b0, 1'b0, 9'h0, 16'h0, 16'h0300);
        doReset();
        idle(1'b1, 1'b0);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 3000; i++) begin
            bit r;
            r = mHalted ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 199) == 0);
            applyStimulus(r, $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0,
                          $urandom_range(0, 59) == 0, $urandom_range(0, 3) == 0,
                          1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          9'($urandom), 16'($urandom), 16'($urandom));
        end

        for (int i = 0; i < 5 && expQ.size() > 0; i++) begin
            @(posedge clk);
            #3;
        end
        if (expQ.size() > 0) begin
            checksTotal++;
            $display("[TB] FAIL drain: %0d expected entries left, required 0", expQ.size());
        end

        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule
